// File: rtl/pov_fb_sequencer_if.sv
// Command, CPU-write and framebuffer-write bundle for pov_fb_sequencer.
// master drives commands/CPU writes/theta; slave (the sequencer) drives fb_* and status.
interface pov_fb_sequencer_if #(
  parameter int COL_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [COL_W-1:0] cmd_start;
  logic [COL_W-1:0] cmd_end;
  logic [23:0]      cmd_color;
  logic             cpu_wr_valid;
  logic [COL_W-1:0] cpu_wr_col;
  logic [23:0]      cpu_wr_data;
  logic [5:0]       theta;
  logic             fb_we;
  logic [COL_W-1:0] fb_addr;
  logic [23:0]      fb_wdata;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_start, cmd_end, cmd_color,
    output cpu_wr_valid, cpu_wr_col, cpu_wr_data, theta,
    input  cmd_ready, fb_we, fb_addr, fb_wdata, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_end, cmd_color,
    input  cpu_wr_valid, cpu_wr_col, cpu_wr_data, theta,
    output cmd_ready, fb_we, fb_addr, fb_wdata, busy, done
  );
endinterface

// File: rtl/pov_fb_sequencer.sv
// POV framebuffer fill sequencer: writes a colour over a (wrapping) column range,
// with CPU writes taking priority. Optional tear guard via `define POV_TEAR_GUARD_EN.
module pov_fb_sequencer #(
  parameter int N_COLS = 256,
  parameter int COL_W  = 8
) (
  input logic               clk,
  input logic               reset,
  pov_fb_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           state;
  logic [COL_W-1:0] fill_ptr;
  logic [COL_W-1:0] end_col;
  logic [23:0]      color_q;
  logic [COL_W-1:0] ptr_next;
  logic             tear_stall;
  logic             fill_write;

`ifdef POV_TEAR_GUARD_EN
  logic [7:0]       group_base;
  logic [COL_W-1:0] group_col;

  // Stall while the pointer sits in the 4-column group currently being displayed.
  always_comb begin
    group_base = {bus.theta, 2'b00};
    group_col  = group_base[COL_W-1:0];
    tear_stall = (fill_ptr >> 2) == (group_col >> 2);
  end
`else
  logic unused_theta;

  assign unused_theta = ^bus.theta;
  assign tear_stall   = 1'b0;
`endif

  always_comb begin
    ptr_next   = (fill_ptr == COL_W'(N_COLS - 1)) ? '0 : fill_ptr + 1'b1;
    fill_write = (state == FILL) && !bus.cpu_wr_valid && !tear_stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      fill_ptr      <= '0;
      end_col       <= '0;
      color_q       <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.fb_we     <= 1'b0;
      bus.fb_addr   <= '0;
      bus.fb_wdata  <= '0;
    end else begin
      bus.fb_we <= 1'b0;
      bus.done  <= 1'b0;

      if (bus.cpu_wr_valid) begin
        bus.fb_we    <= 1'b1;
        bus.fb_addr  <= bus.cpu_wr_col;
        bus.fb_wdata <= bus.cpu_wr_data;
      end else if (fill_write) begin
        bus.fb_we    <= 1'b1;
        bus.fb_addr  <= fill_ptr;
        bus.fb_wdata <= color_q;
        fill_ptr     <= ptr_next;
      end

      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state         <= FILL;
            fill_ptr      <= bus.cmd_start;
            end_col       <= bus.cmd_end;
            color_q       <= bus.cmd_color;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end
        FILL: begin
          if (fill_write && (fill_ptr == end_col)) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pov_fb_sequencer.sv
// Self-checking bench for pov_fb_sequencer: directed literal scenarios plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_pov_fb_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  pov_fb_sequencer_if #(.COL_W(8)) bus ();

  pov_fb_sequencer #(.N_COLS(256), .COL_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a pending fill is just a queue of columns still to write.
  int         mq[$];
  bit         m_in_done;
  bit         m_idle;
  bit         m_guard;
  logic [23:0] m_color;
  logic        exp_we    = 1'b0;
  logic [7:0]  exp_addr  = '0;
  logic [23:0] exp_data  = '0;
  logic        exp_done  = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_busy  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_in_done = 1'b0;
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      exp_done = 1'b0; exp_ready = 1'b1; exp_busy = 1'b0;
    end else begin
      m_idle    = (mq.size() == 0) && !m_in_done;
      m_in_done = 1'b0;
      exp_we    = 1'b0;
      exp_done  = 1'b0;
      m_guard   = 1'b0;
`ifdef POV_TEAR_GUARD_EN
      if (mq.size() > 0) m_guard = ((mq[0] / 4) == int'(bus.theta));
`endif
      if (bus.cpu_wr_valid) begin
        exp_we = 1'b1; exp_addr = bus.cpu_wr_col; exp_data = bus.cpu_wr_data;
      end else if (mq.size() > 0 && !m_guard) begin
        exp_we = 1'b1; exp_addr = 8'(mq.pop_front()); exp_data = m_color;
        if (mq.size() == 0) begin
          m_in_done = 1'b1;
          exp_done  = 1'b1;
        end
      end
      if (m_idle && bus.cmd_valid) begin
        m_color = bus.cmd_color;
        for (int i = 0; i <= ((int'(bus.cmd_end) - int'(bus.cmd_start)) & 255); i++)
          mq.push_back((int'(bus.cmd_start) + i) & 255);
      end
      exp_ready = (mq.size() == 0) && !m_in_done;
      exp_busy  = !exp_ready;
    end
  end

  always @(negedge clk) begin
    check("cmp_fb_we",     bus.fb_we,     exp_we);
    check("cmp_fb_addr",   bus.fb_addr,   exp_addr);
    check("cmp_fb_wdata",  bus.fb_wdata,  exp_data);
    check("cmp_done",      bus.done,      exp_done);
    check("cmp_cmd_ready", bus.cmd_ready, exp_ready);
    check("cmp_busy",      bus.busy,      exp_busy);
  end

  // Issue one command from IDLE and check the literal write sequence that must follow.
  task automatic run_fill(input string tag, input int s, input int e, input logic [23:0] color,
                          input int cpu_at, input int exp_addr_q[$]);
    int n;
    n = exp_addr_q.size();
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_start = 8'(s); bus.cmd_end = 8'(e); bus.cmd_color = color;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check({tag, "_ready_low"}, bus.cmd_ready, 1'b0);
    bus.cpu_wr_col = 8'd200; bus.cpu_wr_data = 24'h00FF00;
    bus.cpu_wr_valid = (cpu_at == 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_we"},   bus.fb_we,   1'b1);
      check({tag, "_addr"}, bus.fb_addr, exp_addr_q[i]);
      check({tag, "_data"}, bus.fb_wdata, (cpu_at == i + 1) ? 24'h00FF00 : color);
      check({tag, "_done"}, bus.done,    (i == n - 1));
      bus.cpu_wr_valid = (cpu_at == i + 2);
    end
    @(negedge clk);
    check({tag, "_ready_after"}, bus.cmd_ready, 1'b1);
    check({tag, "_we_after"},    bus.fb_we,     1'b0);
    check({tag, "_done_after"},  bus.done,      1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_start = '0; bus.cmd_end = '0; bus.cmd_color = '0;
    bus.cpu_wr_valid = 1'b0; bus.cpu_wr_col = '0; bus.cpu_wr_data = '0; bus.theta = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_busy",  bus.busy,      1'b0);
    check("rst_done",  bus.done,      1'b0);
    check("rst_we",    bus.fb_we,     1'b0);
    check("rst_addr",  bus.fb_addr,   8'd0);
    check("rst_wdata", bus.fb_wdata,  24'd0);
    reset = 1'b0;

    run_fill("basic",  10, 13, 24'hFF0000, 0, '{10, 11, 12, 13});
    run_fill("wrap",  254,  1, 24'h0000FF, 0, '{254, 255, 0, 1});
    run_fill("cpu",     0,  7, 24'h123456, 3, '{0, 1, 200, 2, 3, 4, 5, 6, 7});
    run_fill("single",  5,  5, 24'hABCDEF, 0, '{5});
`ifndef POV_TEAR_GUARD_EN
    bus.theta = 6'd2;
    run_fill("theta",   6, 10, 24'h0F0F0F, 0, '{6, 7, 8, 9, 10});
    bus.theta = 6'd0;
`endif

    // Reset while the pointer is at 50 of a 0..99 fill.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_start = 8'd0; bus.cmd_end = 8'd99; bus.cmd_color = 24'h777777;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_last_addr", bus.fb_addr, 8'd49);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", bus.cmd_ready, 1'b1);
    check("abort_busy",  bus.busy,      1'b0);
    check("abort_we",    bus.fb_we,     1'b0);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      check("abort_no_write", bus.fb_we, 1'b0);
      check("abort_no_done",  bus.done,  1'b0);
    end

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset            = ($urandom_range(0, 399) == 0);
      bus.cmd_valid    = ($urandom_range(0, 7) == 0);
      bus.cmd_start    = 8'($urandom_range(0, 255));
      bus.cmd_end      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                      : bus.cmd_start + 8'($urandom_range(0, 15));
      bus.cmd_color    = 24'($urandom);
      bus.cpu_wr_valid = ($urandom_range(0, 4) == 0);
      bus.cpu_wr_col   = 8'($urandom_range(0, 255));
      bus.cpu_wr_data  = 24'($urandom);
      bus.theta        = 6'($urandom_range(0, 63));
    end
    @(negedge clk);
    reset = 1'b0; bus.cmd_valid = 1'b0; bus.cpu_wr_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("final_idle", bus.cmd_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
